// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // Width of the PC field carried in buffer entries; the stage's ADDR_W must not exceed it.
  localparam int FETCH_ADDR_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0]             NOP_INSTR        = 32'h0000_0000;

  // One buffered fetch: the word and the PC it was read from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order synchronous FIFO of fetch entries with a single-cycle flush.
// Used both as the request-PC tag queue and as the instruction buffer.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers/count; flush wins over a same-cycle push or pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty && !flush));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads to imem under a
// credit limit, buffers returned words with their PC, and hands them to decode.
// A redirect flushes buffered words and discards responses still in flight.
//
// Decode handshake: instValid/instruction/pcOut/pcPlus4 are held stable while
// instValid=1 and decodeReady=0; a word moves to decode on any rising edge where
// instValid & decodeReady are both 1, and instValid never depends on decodeReady.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [FETCH_ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                      FIFO_DEPTH = 2,
  parameter int                      ADDR_W     = FETCH_ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemValid,
  input  logic [31:0]       imemData,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectTarget,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] pcOut,
  output logic [ADDR_W-1:0] pcPlus4,
  output logic              instValid,
  input  logic              decodeReady
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CR_W  = CNT_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  fetch_entry_t      tag_head, tag_push_data;
  fetch_entry_t      buf_head, buf_push_data;
  logic [CNT_W-1:0]  tag_count, buf_count;
  logic              tag_full, tag_empty, buf_full, buf_empty;
  logic              transfer, resp_live, buf_push;
  logic [CR_W-1:0]   credit_used;

  assign instValid = !buf_empty;
  assign transfer  = instValid && decodeReady;
  assign resp_live = imemValid && (drop_q == '0);
  assign buf_push  = resp_live && !redirect;

  // Slots in use once this cycle's decode transfer leaves; counting the
  // departing word lets a freed slot be refilled at once (1 instr/cycle).
  assign credit_used = CR_W'(out_q) + CR_W'(buf_count) - CR_W'(transfer);
  assign imemReq     = !Rst && !redirect && (credit_used < CR_W'(FIFO_DEPTH));
  assign imemAddr    = pc_q;

  assign tag_push_data = '{pc: FETCH_ADDR_W'(pc_q), instr: NOP_INSTR};
  assign buf_push_data = '{pc: tag_head.pc, instr: imemData};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk       (Clk),
    .rst       (Rst),
    .push      (imemReq),
    .push_data (tag_push_data),
    .pop       (resp_live),
    .flush     (redirect),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count),
    .head      (tag_head)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_inst_buf (
    .clk       (Clk),
    .rst       (Rst),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (transfer),
    .flush     (redirect),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count),
    .head      (buf_head)
  );

  // Next PC and in-flight/discard counters.
  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (redirect) begin
      pc_d = {redirectTarget[ADDR_W-1:2], 2'b00};
    end else if (imemReq) begin
      pc_d = pc_q + ADDR_W'(4);
    end
    case ({imemReq, imemValid})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase
    // Every read still in flight after a redirect belongs to the old path.
    if (redirect) begin
      drop_d = out_d;
    end else if (imemValid && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end
  end

  // PC and counter registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q   <= ADDR_W'(RESET_PC);
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  // An empty buffer presents a NOP at the current fetch PC.
  always_comb begin
    instruction = NOP_INSTR;
    pcOut       = pc_q;
    if (!buf_empty) begin
      instruction = buf_head.instr;
      pcOut       = ADDR_W'(buf_head.pc);
    end
    pcPlus4 = pcOut + ADDR_W'(4);
  end

  a_resp_expected: assert property (@(posedge Clk) disable iff (Rst) imemValid |-> (out_q != '0));
  a_buf_room:      assert property (@(posedge Clk) disable iff (Rst) !(buf_push && buf_full));
  a_tag_room:      assert property (@(posedge Clk) disable iff (Rst) !(imemReq && tag_full));
  a_tag_live:      assert property (@(posedge Clk) disable iff (Rst) resp_live |-> !tag_empty);
  a_tag_balance:   assert property (@(posedge Clk) disable iff (Rst)
                                    (CR_W'(tag_count) + CR_W'(drop_q)) == CR_W'(out_q));
  a_tag_payload:   assert property (@(posedge Clk) disable iff (Rst)
                                    !tag_empty |-> (tag_head.instr == NOP_INSTR));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order imem with random latency, random decode
// back-pressure, redirects and resets, checked against a queue-level model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 2;

  logic        Clk = 1'b0;
  logic        Rst, imemReq, imemValid, redirect, instValid, decodeReady;
  logic [31:0] imemAddr, imemData, redirectTarget, instruction, pcOut, pcPlus4;

  fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemValid      (imemValid),
    .imemData       (imemData),
    .redirect       (redirect),
    .redirectTarget (redirectTarget),
    .instruction    (instruction),
    .pcOut          (pcOut),
    .pcPlus4        (pcPlus4),
    .instValid      (instValid),
    .decodeReady    (decodeReady)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          due;
  } rd_t;

  rd_t         inflight[$];   // reads issued to imem, oldest first
  int          bufcnt;        // words fetched on the current path not yet taken by decode
  int          epoch, cyc, last_due;
  int          lat_lo, lat_hi, p_ready, p_redirect;
  logic [31:0] exp_pc;        // next PC decode should see
  logic [31:0] exp_req_pc;    // next PC imem should be asked for
  logic [31:0] data_key;
  bit          after_rst;

  // events observed in the last sampled cycle
  bit          ev_rst, ev_redirect, ev_req, ev_resp, ev_valid, ev_xfer;
  logic [31:0] ev_tgt, ev_addr, ev_pc;

  int n_cmp, n_bad;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare outputs mid-cycle against the model and record this cycle's events.
  task automatic sample();
    bit exp_valid, exp_xfer, exp_req;
    int used;
    exp_valid = (bufcnt > 0);
    exp_xfer  = exp_valid && decodeReady;
    used      = inflight.size() + bufcnt - (exp_xfer ? 1 : 0);
    exp_req   = !Rst && !redirect && (used < DEPTH);
    if (!Rst) begin
      check("inst_valid", 32'(instValid), 32'(exp_valid));
      if (exp_valid) begin
        check("pc_out", pcOut, exp_pc);
        check("instruction", instruction, exp_pc ^ data_key);
        check("pc_plus4", pcPlus4, exp_pc + 32'd4);
      end
      if (after_rst) begin
        check("rst_instr_nop", instruction, NOP_INSTR);
        check("rst_pc_out", pcOut, RST_PC);
      end
      check("imem_addr", imemAddr, exp_req_pc);
    end
    check("imem_req", 32'(imemReq), 32'(exp_req));
    ev_rst      = Rst;
    ev_redirect = redirect;
    ev_tgt      = redirectTarget;
    ev_req      = imemReq;
    ev_addr     = imemAddr;
    ev_resp     = imemValid;
    ev_valid    = instValid;
    ev_pc       = pcOut;
    ev_xfer     = exp_xfer;
  endtask

  // Advance the model by the edge that just happened.
  task automatic update();
    rd_t r;
    int  lat;
    if (ev_rst) begin
      inflight.delete();
      bufcnt     = 0;
      exp_pc     = RST_PC;
      exp_req_pc = RST_PC;
      epoch++;
      after_rst  = 1'b1;
      last_due   = cyc;
    end else begin
      after_rst = 1'b0;
      if (ev_resp) begin
        r = inflight.pop_front();
        if (r.epoch == epoch) bufcnt++;
      end
      if (ev_xfer) begin
        bufcnt--;
        exp_pc = exp_pc + 32'd4;
      end
      if (ev_req) begin
        lat      = $urandom_range(lat_hi, lat_lo);
        r.addr   = ev_addr;
        r.data   = ev_addr ^ data_key;
        r.epoch  = epoch;
        r.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = r.due;
        inflight.push_back(r);
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (ev_redirect) begin
        epoch++;
        bufcnt     = 0;
        exp_pc     = {ev_tgt[31:2], 2'b00};
        exp_req_pc = {ev_tgt[31:2], 2'b00};
      end
    end
    cyc++;
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    imemValid      = (inflight.size() > 0) && (inflight[0].due <= cyc);
    imemData       = imemValid ? inflight[0].data : $urandom;
    decodeReady    = ($urandom_range(99, 0) < p_ready);
    redirect       = ($urandom_range(99, 0) < p_redirect);
    redirectTarget = $urandom;
  endtask

  task automatic cycle();
    @(negedge Clk);
    sample();
    @(posedge Clk);
    #1;
    update();
    drive();
  endtask

  task automatic reset_dut(input int n);
    Rst = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    Rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          first, nvalid, waited;
    logic [31:0] held;

    n_cmp = 0; n_bad = 0; cyc = 0; epoch = 0; last_due = 0; bufcnt = 0;
    exp_pc = RST_PC; exp_req_pc = RST_PC; after_rst = 1'b0; data_key = 32'h0;
    lat_lo = 1; lat_hi = 1; p_ready = 100; p_redirect = 0;
    Rst = 1'b1; redirect = 1'b0; redirectTarget = '0; decodeReady = 1'b1;
    imemValid = 1'b0; imemData = '0;

    // 1+5: latency, full rate, PC wrap FFFF_FFF8 -> FFFF_FFFC -> 0
    reset_dut(3);
    first = -1; nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (ev_valid && first < 0) first = i;
      if (ev_valid) nvalid++;
    end
    check("first_valid_cycle", 32'(first), 32'd2);
    check("stream_rate", 32'(nvalid), 32'd10);

    // 2: decode stalls for 5 cycles; head must hold and requests stop
    for (int k = 0; k < 5; k++) begin
      decodeReady = 1'b0;
      cycle();
      if (k == 0) held = ev_pc;
      else check("stall_head_hold", ev_pc, held);
    end
    check("stall_req_stopped", 32'(ev_req), 32'd0);
    for (int i = 0; i < 6; i++) cycle();

    // 3: slow imem, redirect with two reads in flight
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 8; i++) cycle();
    waited = 0;
    while (inflight.size() != 2 && waited < 20) begin
      cycle();
      waited++;
    end
    check("t3_two_inflight", 32'(inflight.size()), 32'd2);
    redirect = 1'b1; redirectTarget = 32'h0000_0103;
    cycle();
    cycle();
    check("t3_redirect_addr", ev_addr, 32'h0000_0100);
    waited = 0;
    while (!ev_valid && waited < 20) begin
      cycle();
      waited++;
    end
    check("t3_first_after_redirect", ev_pc, 32'h0000_0100);

    // 4: redirect together with a response and a decode transfer
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 8; i++) cycle();
    redirect = 1'b1; redirectTarget = 32'h0000_0200; decodeReady = 1'b1;
    cycle();
    check("t4_had_transfer", 32'(ev_valid), 32'd1);
    cycle();
    check("t4_valid_after_redirect", 32'(ev_valid), 32'd0);
    for (int i = 0; i < 6; i++) cycle();

    // 6: reset while stalled with words buffered and reads in flight
    lat_lo = 3; lat_hi = 3; p_ready = 0;
    for (int i = 0; i < 6; i++) cycle();
    data_key = 32'h1357_9BDF;
    reset_dut(1);
    p_ready = 100;
    cycle();
    check("t6_valid_after_rst", 32'(ev_valid), 32'd0);
    check("t6_addr_after_rst", ev_addr, RST_PC);
    check("t6_req_after_rst", 32'(ev_req), 32'd1);
    for (int i = 0; i < 10; i++) cycle();

    // random soak: latency, back-pressure, redirects, occasional reset
    lat_lo = 1; lat_hi = 4; p_ready = 70; p_redirect = 8;
    for (int i = 0; i < 3000; i++) begin
      Rst = ($urandom_range(199, 0) == 0);
      cycle();
    end
    Rst = 1'b0;
    p_redirect = 0; p_ready = 100;
    for (int i = 0; i < 20; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
